exu_disp_mc: RTL

Multi-channel registered dispatcher between the decode/regfile-read stage and NCH execution channels (ALU, LSU, MDU, ...). It routes each decoded instruction to one channel through a per-channel one-entry output slot with valid/ready handshake, masking x0 operands. An in-order outstanding-write table (OITF) tracks rd writes of long-latency channels and stalls dispatch on RAW/WAW hazards.

---
 rtl/exu_disp_mc_pkg.sv | 25 ++
 rtl/exu_disp_mc_if.sv | 52 +++++
 rtl/exu_disp_oitf.sv | 68 ++++++
 rtl/exu_disp_mc.sv | 114 +++++++++++
 4 files changed

// File: rtl/exu_disp_mc_pkg.sv
// Shared widths, channel IDs and the slot payload record for the multi-channel dispatcher.
package exu_disp_mc_pkg;

    localparam int XLEN          = 32;
    localparam int RFIDX_WIDTH   = 5;
    localparam int DECINFO_WIDTH = 16;
    localparam int PC_SIZE       = 32;

    typedef enum logic [1:0] {
        DISP_CH_ALU = 2'd0,
        DISP_CH_LSU = 2'd1,
        DISP_CH_MDU = 2'd2
    } disp_ch_e;

    typedef struct packed {
        logic [XLEN-1:0]          rs1;
        logic [XLEN-1:0]          rs2;
        logic                     rdwen;
        logic [RFIDX_WIDTH-1:0]   rdidx;
        logic [DECINFO_WIDTH-1:0] info;
        logic [XLEN-1:0]          imm;
        logic [PC_SIZE-1:0]       pc;
    } disp_pld_t;

endpackage

// File: rtl/exu_disp_mc_if.sv
// Dispatch bus: decode-side request, per-channel output slots, commit port and OITF occupancy.
interface exu_disp_mc_if
    import exu_disp_mc_pkg::*;
#(
    parameter int NCH        = 3,
    parameter int OSTD_DEPTH = 4
);
    logic                         disp_i_valid;
    logic                         disp_i_ready;
    logic [NCH-1:0]               disp_i_chsel;
    logic                         disp_i_rs1x0;
    logic                         disp_i_rs2x0;
    logic                         disp_i_rs1en;
    logic                         disp_i_rs2en;
    logic [RFIDX_WIDTH-1:0]       disp_i_rs1idx;
    logic [RFIDX_WIDTH-1:0]       disp_i_rs2idx;
    logic [XLEN-1:0]              disp_i_rs1;
    logic [XLEN-1:0]              disp_i_rs2;
    logic                         disp_i_rdwen;
    logic [RFIDX_WIDTH-1:0]       disp_i_rdidx;
    logic [DECINFO_WIDTH-1:0]     disp_i_info;
    logic [XLEN-1:0]              disp_i_imm;
    logic [PC_SIZE-1:0]           disp_i_pc;
    logic [NCH-1:0]               disp_o_valid;
    logic [NCH-1:0]               disp_o_ready;
    logic [NCH*XLEN-1:0]          disp_o_rs1;
    logic [NCH*XLEN-1:0]          disp_o_rs2;
    logic [NCH-1:0]               disp_o_rdwen;
    logic [NCH*RFIDX_WIDTH-1:0]   disp_o_rdidx;
    logic [NCH*DECINFO_WIDTH-1:0] disp_o_info;
    logic [NCH*XLEN-1:0]          disp_o_imm;
    logic [NCH*PC_SIZE-1:0]       disp_o_pc;
    logic                         disp_i_cmt_valid;
    logic [XLEN-1:0]              disp_i_cmt_data;
    logic [$clog2(OSTD_DEPTH):0]  disp_o_ostd_cnt;

    modport slave (
        input  disp_i_valid, disp_i_chsel, disp_i_rs1x0, disp_i_rs2x0, disp_i_rs1en, disp_i_rs2en,
        input  disp_i_rs1idx, disp_i_rs2idx, disp_i_rs1, disp_i_rs2, disp_i_rdwen, disp_i_rdidx,
        input  disp_i_info, disp_i_imm, disp_i_pc, disp_o_ready, disp_i_cmt_valid, disp_i_cmt_data,
        output disp_i_ready, disp_o_valid, disp_o_rs1, disp_o_rs2, disp_o_rdwen, disp_o_rdidx,
        output disp_o_info, disp_o_imm, disp_o_pc, disp_o_ostd_cnt
    );

    modport master (
        output disp_i_valid, disp_i_chsel, disp_i_rs1x0, disp_i_rs2x0, disp_i_rs1en, disp_i_rs2en,
        output disp_i_rs1idx, disp_i_rs2idx, disp_i_rs1, disp_i_rs2, disp_i_rdwen, disp_i_rdidx,
        output disp_i_info, disp_i_imm, disp_i_pc, disp_o_ready, disp_i_cmt_valid, disp_i_cmt_data,
        input  disp_i_ready, disp_o_valid, disp_o_rs1, disp_o_rs2, disp_o_rdwen, disp_o_rdidx,
        input  disp_o_info, disp_o_imm, disp_o_pc, disp_o_ostd_cnt
    );
endinterface

// File: rtl/exu_disp_oitf.sv
// Outstanding-write FIFO of rd indices with CAM lookups for rs1/rs2/rd and occupancy flags.
module exu_disp_oitf #(
    parameter int DEPTH = 4,
    parameter int IDXW  = 5
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_i,
    input  logic [IDXW-1:0]         alloc_idx_i,
    input  logic                    retire_i,
    input  logic [IDXW-1:0]         rs1idx_i,
    input  logic [IDXW-1:0]         rs2idx_i,
    input  logic [IDXW-1:0]         rdidx_i,
    output logic                    rs1_hit_o,
    output logic                    rs1_hit_nh_o,
    output logic                    rs2_hit_o,
    output logic                    rs2_hit_nh_o,
    output logic                    rd_hit_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  cnt_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [IDXW-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] ent_vld, is_head, rs1_m, rs2_m, rd_m;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign cnt_o   = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign wptr_d  = wptr_q + {{AW{1'b0}}, alloc_i};
    assign rptr_d  = rptr_q + {{AW{1'b0}}, retire_i};

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        localparam logic [AW-1:0] SLOT = AW'(gi);
        logic [AW-1:0] ofs;
        assign ofs         = SLOT - rptr_q[AW-1:0];
        assign ent_vld[gi] = ({1'b0, ofs} < cnt_o);
        assign is_head[gi] = (SLOT == rptr_q[AW-1:0]);
        assign rs1_m[gi]   = ent_vld[gi] && (mem_q[gi] == rs1idx_i);
        assign rs2_m[gi]   = ent_vld[gi] && (mem_q[gi] == rs2idx_i);
        assign rd_m[gi]    = ent_vld[gi] && (mem_q[gi] == rdidx_i);
    end

    assign rs1_hit_o    = |rs1_m;
    assign rs1_hit_nh_o = |(rs1_m & ~is_head);
    assign rs2_hit_o    = |rs2_m;
    assign rs2_hit_nh_o = |(rs2_m & ~is_head);
    assign rd_hit_o     = |rd_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is qualified by ent_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_i)
            mem_q[wptr_q[AW-1:0]] <= alloc_idx_i;
    end
endmodule

// File: rtl/exu_disp_mc.sv
// Registered multi-channel dispatcher with per-channel output slots and OITF hazard stalls.
// Optional DISP_BYPASS_EN: forwards retiring write data to a source that only hits the OITF head.
module exu_disp_mc
    import exu_disp_mc_pkg::*;
#(
    parameter int             NCH        = 3,
    parameter logic [NCH-1:0] LONG_MASK  = 3'b110,
    parameter int             OSTD_DEPTH = 4
)(
    input logic          clk,
    input logic          rst,
    exu_disp_mc_if.slave bus
);
    localparam logic [NCH-1:0] CH_ONE = NCH'(1);

    logic rs1_hit, rs1_hit_nh, rs2_hit, rs2_hit_nh, rd_hit, oitf_full, oitf_empty;
    logic chsel_ok, sel_free, long_sel, oitf_alloc, accept, retire;
    logic rs1_chk, rs2_chk, rs1_byp, rs2_byp, src_haz, waw_haz;
    logic [NCH-1:0] slot_vld, slot_free;
    disp_pld_t pld_d;

    exu_disp_oitf #(.DEPTH(OSTD_DEPTH), .IDXW(RFIDX_WIDTH)) u_oitf (
        .clk          (clk),
        .rst          (rst),
        .alloc_i      (accept & oitf_alloc),
        .alloc_idx_i  (bus.disp_i_rdidx),
        .retire_i     (retire),
        .rs1idx_i     (bus.disp_i_rs1idx),
        .rs2idx_i     (bus.disp_i_rs2idx),
        .rdidx_i      (bus.disp_i_rdidx),
        .rs1_hit_o    (rs1_hit),
        .rs1_hit_nh_o (rs1_hit_nh),
        .rs2_hit_o    (rs2_hit),
        .rs2_hit_nh_o (rs2_hit_nh),
        .rd_hit_o     (rd_hit),
        .full_o       (oitf_full),
        .empty_o      (oitf_empty),
        .cnt_o        (bus.disp_o_ostd_cnt)
    );

    assign retire     = bus.disp_i_cmt_valid & ~oitf_empty;
    assign slot_free  = ~slot_vld | bus.disp_o_ready;
    assign chsel_ok   = (bus.disp_i_chsel != '0) && ((bus.disp_i_chsel & (bus.disp_i_chsel - CH_ONE)) == '0);
    assign sel_free   = |(bus.disp_i_chsel & slot_free);
    assign long_sel   = |(bus.disp_i_chsel & LONG_MASK);
    assign oitf_alloc = long_sel & bus.disp_i_rdwen & (bus.disp_i_rdidx != '0);
    assign rs1_chk    = bus.disp_i_rs1en & ~bus.disp_i_rs1x0;
    assign rs2_chk    = bus.disp_i_rs2en & ~bus.disp_i_rs2x0;

`ifdef DISP_BYPASS_EN
    assign rs1_byp = rs1_chk & bus.disp_i_cmt_valid & rs1_hit & ~rs1_hit_nh;
    assign rs2_byp = rs2_chk & bus.disp_i_cmt_valid & rs2_hit & ~rs2_hit_nh;
`else
    logic unused_byp;
    assign rs1_byp    = 1'b0;
    assign rs2_byp    = 1'b0;
    assign unused_byp = ^{bus.disp_i_cmt_data, rs1_hit_nh, rs2_hit_nh};
`endif

    // A match against the retiring head still stalls unless bypassed: the regfile write lands at this edge.
    assign src_haz = (rs1_chk & rs1_hit & ~rs1_byp) | (rs2_chk & rs2_hit & ~rs2_byp);
    assign waw_haz = bus.disp_i_rdwen & rd_hit;

    assign bus.disp_i_ready = chsel_ok & sel_free & ~src_haz & ~waw_haz
                            & ~(oitf_alloc & oitf_full & ~bus.disp_i_cmt_valid);
    assign accept = bus.disp_i_valid & bus.disp_i_ready;

    always_comb begin
        pld_d       = '0;
        pld_d.rs1   = (rs1_byp ? bus.disp_i_cmt_data : bus.disp_i_rs1) & ~{XLEN{bus.disp_i_rs1x0}};
        pld_d.rs2   = (rs2_byp ? bus.disp_i_cmt_data : bus.disp_i_rs2) & ~{XLEN{bus.disp_i_rs2x0}};
        pld_d.rdwen = bus.disp_i_rdwen;
        pld_d.rdidx = bus.disp_i_rdidx;
        pld_d.info  = bus.disp_i_info;
        pld_d.imm   = bus.disp_i_imm;
        pld_d.pc    = bus.disp_i_pc;
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
        logic      vld_q;
        disp_pld_t pld_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                pld_q <= '0;
            end else if (accept && bus.disp_i_chsel[gi]) begin
                vld_q <= 1'b1;
                pld_q <= pld_d;
            end else if (bus.disp_o_ready[gi]) begin
                vld_q <= 1'b0;
            end
        end

        assign slot_vld[gi]                                          = vld_q;
        assign bus.disp_o_valid[gi]                                  = vld_q;
        assign bus.disp_o_rs1[gi*XLEN +: XLEN]                       = pld_q.rs1;
        assign bus.disp_o_rs2[gi*XLEN +: XLEN]                       = pld_q.rs2;
        assign bus.disp_o_rdwen[gi]                                  = pld_q.rdwen;
        assign bus.disp_o_rdidx[gi*RFIDX_WIDTH +: RFIDX_WIDTH]       = pld_q.rdidx;
        assign bus.disp_o_info[gi*DECINFO_WIDTH +: DECINFO_WIDTH]    = pld_q.info;
        assign bus.disp_o_imm[gi*XLEN +: XLEN]                       = pld_q.imm;
        assign bus.disp_o_pc[gi*PC_SIZE +: PC_SIZE]                  = pld_q.pc;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (bus.disp_i_valid)     assert (chsel_ok);
            if (bus.disp_i_cmt_valid) assert (!oitf_empty);
        end
    end
`endif
endmodule
